// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types and constants for the skid-buffered pipeline stage
// Purpose: state encoding and occupancy width used by the stage, its interface and the bench.
// Ports: none (package).
package pipe_pkg;

  localparam int PIPE_OCC_W = 2;

  // Encoding equals the number of held entries, so occ is the state itself.
  typedef enum logic [PIPE_OCC_W-1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } pipe_state_e;

  function automatic logic [PIPE_OCC_W-1:0] state_occ(input pipe_state_e s);
    return PIPE_OCC_W'(s);
  endfunction

endpackage

// File: rtl/pipe_stage_skid_if.sv
// rtl/pipe_stage_skid_if.sv - upstream/downstream handshake bundle of the pipeline stage
// Purpose: groups the valid/ready/ctrl/data signals on both sides of the stage plus occupancy.
// Ports (slave = stage view):
//   in_valid/in_ctrl/in_data  in   upstream entry
//   in_ready                  out  stage accepts an entry this cycle
//   out_valid/out_ctrl/out_data out head entry
//   out_ready                 in   downstream accepts the head entry
//   occ                       out  number of held entries
interface pipe_stage_skid_if import pipe_pkg::*; #(
  parameter int CTRL_W = 12,
  parameter int DATA_W = 160
) ();

  logic                  in_valid;
  logic                  in_ready;
  logic [CTRL_W-1:0]     in_ctrl;
  logic [DATA_W-1:0]     in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [CTRL_W-1:0]     out_ctrl;
  logic [DATA_W-1:0]     out_data;
  logic [PIPE_OCC_W-1:0] occ;

  modport master (
    output in_valid, in_ctrl, in_data, out_ready,
    input  in_ready, out_valid, out_ctrl, out_data, occ
  );

  modport slave (
    input  in_valid, in_ctrl, in_data, out_ready,
    output in_ready, out_valid, out_ctrl, out_data, occ
  );

endinterface

// File: rtl/pipe_slot.sv
// rtl/pipe_slot.sv - one ctrl+data entry register with load and clear
// Purpose: storage for one pipeline entry; full clear wipes ctrl and data, ctrl clear kills only the ctrl.
// Ports:
//   Clk       in  clock
//   rst       in  zero ctrl and data (highest priority)
//   clr_ctrl  in  zero ctrl only, data retained
//   load      in  capture d_ctrl/d_data
//   d_ctrl/d_data  in   next entry
//   q_ctrl/q_data  out  held entry
module pipe_slot #(
  parameter int CTRL_W = 12,
  parameter int DATA_W = 160
) (
  input  logic              Clk,
  input  logic              rst,
  input  logic              clr_ctrl,
  input  logic              load,
  input  logic [CTRL_W-1:0] d_ctrl,
  input  logic [DATA_W-1:0] d_data,
  output logic [CTRL_W-1:0] q_ctrl,
  output logic [DATA_W-1:0] q_data
);

  always_ff @(posedge Clk) begin
    if (rst) begin
      q_ctrl <= '0;
      q_data <= '0;
    end else begin
      if (clr_ctrl)  q_ctrl <= '0;
      else if (load) q_ctrl <= d_ctrl;
      if (load && !clr_ctrl) q_data <= d_data;
    end
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// rtl/pipe_stage_skid.sv - two-entry (main + skid) pipeline register stage with stall, flush and reset
// Purpose: decouples in_ready from out_ready; out_* always shows the main entry, skid absorbs one extra.
// Ports:
//   Clk    in  clock
//   Clr    in  synchronous active-high reset
//   Ld     in  stage enable, 0 freezes the stage
//   Flush  in  discard all held entries
//   bus    slave side of pipe_stage_skid_if (handshakes, payloads, occ)
module pipe_stage_skid import pipe_pkg::*; #(
  parameter int DATA_W      = 160,
  parameter int CTRL_W      = 12,
  parameter int BUBBLE_ZERO = 1
) (
  input  logic Clk,
  input  logic Clr,
  input  logic Ld,
  input  logic Flush,
  pipe_stage_skid_if.slave bus
);

  pipe_state_e state_q, state_d;

  logic [CTRL_W-1:0] main_ctrl, skid_ctrl, main_d_ctrl;
  logic [DATA_W-1:0] main_data, skid_data, main_d_data;
  logic in_ready_w, out_valid_w, push, pop;
  logic main_load, skid_load;
  logic [CTRL_W-1:0] out_ctrl_w;

  // State register
  always_ff @(posedge Clk) begin
    if (Clr) state_q <= EMPTY;
    else     state_q <= state_d;
  end

  // Next state; Flush overrides any handshake of the same cycle
  always_comb begin
    state_d = state_q;
    if (Flush) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY:   if (push) state_d = ONE;
        ONE: begin
          if (push && !pop)      state_d = FULL;
          else if (pop && !push) state_d = EMPTY;
        end
        FULL:    if (pop) state_d = ONE;
        default: state_d = EMPTY;
      endcase
    end
  end

  // Outputs and slot controls. Handshakes are masked while Clr is high so
  // nothing is seen to transfer during reset.
  always_comb begin
    in_ready_w  = Ld && !Clr && (state_q != FULL);
    out_valid_w = Ld && !Clr && (state_q != EMPTY);
    push        = bus.in_valid && in_ready_w;
    pop         = out_valid_w && bus.out_ready;
    main_load   = !Flush && (((state_q == EMPTY) && push) ||
                             ((state_q == ONE) && push && pop) ||
                             ((state_q == FULL) && pop));
    skid_load   = !Flush && (state_q == ONE) && push && !pop;
    // In FULL the only main reload is the skid moving forward
    main_d_ctrl = (state_q == FULL) ? skid_ctrl : bus.in_ctrl;
    main_d_data = (state_q == FULL) ? skid_data : bus.in_data;
    out_ctrl_w  = main_ctrl;
    if ((BUBBLE_ZERO != 0) && !out_valid_w) out_ctrl_w = '0;
  end

  pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_main (
    .Clk      (Clk),
    .rst      (Clr),
    .clr_ctrl (Flush),
    .load     (main_load),
    .d_ctrl   (main_d_ctrl),
    .d_data   (main_d_data),
    .q_ctrl   (main_ctrl),
    .q_data   (main_data)
  );

  pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
    .Clk      (Clk),
    .rst      (Clr),
    .clr_ctrl (Flush),
    .load     (skid_load),
    .d_ctrl   (bus.in_ctrl),
    .d_data   (bus.in_data),
    .q_ctrl   (skid_ctrl),
    .q_data   (skid_data)
  );

  assign bus.in_ready  = in_ready_w;
  assign bus.out_valid = out_valid_w;
  assign bus.out_ctrl  = out_ctrl_w;
  assign bus.out_data  = main_data;
  assign bus.occ       = state_occ(state_q);

endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb/tb_pipe_stage_skid.sv - directed self-checking bench for pipe_stage_skid
module tb_pipe_stage_skid;

  logic Clk = 1'b0;
  logic Clr, Ld, Flush;
  int   n_checks = 0;
  int   n_fail   = 0;

  pipe_stage_skid_if #(.CTRL_W(12), .DATA_W(160)) bus ();

  pipe_stage_skid #(.DATA_W(160), .CTRL_W(12), .BUBBLE_ZERO(1)) dut (
    .Clk   (Clk),
    .Clr   (Clr),
    .Ld    (Ld),
    .Flush (Flush),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic push_one(input logic [11:0] c, input logic [159:0] d);
    bus.in_valid = 1'b1;
    bus.in_ctrl  = c;
    bus.in_data  = d;
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    Clr = 1'b1; Ld = 1'b1; Flush = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.in_ctrl = '0; bus.in_data = '0;
    step(); step();
    n_checks++; if (bus.occ !== 2'd0) begin n_fail++; $display("FAIL reset_occ got %0d want 0", bus.occ); end
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
    n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got %b want 0", bus.in_ready); end
    n_checks++; if (bus.out_ctrl !== 12'h0) begin n_fail++; $display("FAIL reset_out_ctrl got %h want 0", bus.out_ctrl); end
    n_checks++; if (bus.out_data !== 160'h0) begin n_fail++; $display("FAIL reset_out_data got %h want 0", bus.out_data); end
    Clr = 1'b0;
    #1;
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_in_ready got %b want 1", bus.in_ready); end
  endtask

  task automatic test_single();
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1; bus.in_ctrl = 12'h001; bus.in_data = 160'hA5;
    step();
    bus.in_valid = 1'b0;
    #1;
    n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL single_out_valid got %b want 1", bus.out_valid); end
    n_checks++; if (bus.out_data !== 160'hA5) begin n_fail++; $display("FAIL single_out_data got %h want a5", bus.out_data); end
    n_checks++; if (bus.out_ctrl !== 12'h001) begin n_fail++; $display("FAIL single_out_ctrl got %h want 001", bus.out_ctrl); end
    n_checks++; if (bus.occ !== 2'd1) begin n_fail++; $display("FAIL single_occ1 got %0d want 1", bus.occ); end
    step();
    n_checks++; if (bus.occ !== 2'd0) begin n_fail++; $display("FAIL single_occ0 got %0d want 0", bus.occ); end
    n_checks++; if (bus.out_ctrl !== 12'h0) begin n_fail++; $display("FAIL single_bubble_ctrl got %h want 0", bus.out_ctrl); end
    n_checks++; if (bus.out_data !== 160'hA5) begin n_fail++; $display("FAIL single_data_retained got %h want a5", bus.out_data); end
  endtask

  task automatic test_fill_drain();
    bus.out_ready = 1'b0;
    push_one(12'h011, 160'h11);
    push_one(12'h022, 160'h22);
    #1;
    n_checks++; if (bus.occ !== 2'd2) begin n_fail++; $display("FAIL fill_occ got %0d want 2", bus.occ); end
    n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL fill_in_ready got %b want 0", bus.in_ready); end
    n_checks++; if (bus.out_data !== 160'h11) begin n_fail++; $display("FAIL fill_head got %h want 11", bus.out_data); end
    bus.out_ready = 1'b1;
    step();
    n_checks++; if (bus.out_data !== 160'h22 || bus.out_ctrl !== 12'h022) begin n_fail++; $display("FAIL drain_second got %h/%h want 22/022", bus.out_data, bus.out_ctrl); end
    n_checks++; if (bus.occ !== 2'd1) begin n_fail++; $display("FAIL drain_occ1 got %0d want 1", bus.occ); end
    step();
    n_checks++; if (bus.occ !== 2'd0 || bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL drain_empty got occ=%0d valid=%b want 0/0", bus.occ, bus.out_valid); end
  endtask

  task automatic test_flush();
    bus.out_ready = 1'b0;
    push_one(12'h033, 160'h33);
    push_one(12'h044, 160'h44);
    n_checks++; if (bus.occ !== 2'd2) begin n_fail++; $display("FAIL flush_pre_occ got %0d want 2", bus.occ); end
    Flush = 1'b1; bus.in_valid = 1'b1; bus.in_ctrl = 12'h055; bus.in_data = 160'h55; bus.out_ready = 1'b1;
    step();
    Flush = 1'b0; bus.in_valid = 1'b0;
    #1;
    n_checks++; if (bus.occ !== 2'd0) begin n_fail++; $display("FAIL flush_occ got %0d want 0", bus.occ); end
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_out_valid got %b want 0", bus.out_valid); end
    n_checks++; if (bus.out_ctrl !== 12'h0) begin n_fail++; $display("FAIL flush_out_ctrl got %h want 0", bus.out_ctrl); end
    step();
    n_checks++; if (bus.occ !== 2'd0) begin n_fail++; $display("FAIL flush_push_ignored got occ=%0d want 0", bus.occ); end
  endtask

  task automatic test_hold();
    bus.out_ready = 1'b0;
    push_one(12'h05A, 160'h5A);
    bus.in_valid = 1'b1; bus.in_ctrl = 12'h066; bus.in_data = 160'h66; bus.out_ready = 1'b1;
    Ld = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_checks++; if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.occ !== 2'd1) begin
        n_fail++; $display("FAIL hold_cycle%0d got rdy=%b vld=%b occ=%0d want 0/0/1", k, bus.in_ready, bus.out_valid, bus.occ);
      end
      step();
    end
    Ld = 1'b1; bus.in_valid = 1'b0;
    #1;
    n_checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 160'h5A || bus.out_ctrl !== 12'h05A) begin
      n_fail++; $display("FAIL hold_represent got vld=%b data=%h ctrl=%h want 1/5a/05a", bus.out_valid, bus.out_data, bus.out_ctrl);
    end
    step();
    n_checks++; if (bus.occ !== 2'd0) begin n_fail++; $display("FAIL hold_drained got occ=%0d want 0", bus.occ); end
  endtask

  task automatic test_back_to_back();
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      bus.in_ctrl = 12'(i + 1);
      bus.in_data = 160'(i + 1000);
      #1;
      if (i > 0) begin
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 160'(i + 999) || bus.out_ctrl !== 12'(i) || bus.occ !== 2'd1) begin
          n_fail++; $display("FAIL b2b_%0d got vld=%b data=%0d ctrl=%0d occ=%0d want 1/%0d/%0d/1",
                             i, bus.out_valid, bus.out_data, bus.out_ctrl, bus.occ, i + 999, i);
        end
      end
      step();
    end
    bus.in_valid = 1'b0;
    #1;
    n_checks++; if (bus.out_data !== 160'd1099 || bus.occ !== 2'd1) begin n_fail++; $display("FAIL b2b_last got data=%0d occ=%0d want 1099/1", bus.out_data, bus.occ); end
    step();
    n_checks++; if (bus.occ !== 2'd0) begin n_fail++; $display("FAIL b2b_empty got occ=%0d want 0", bus.occ); end
  endtask

  task automatic test_clr_full();
    bus.out_ready = 1'b0;
    push_one(12'h077, 160'h77);
    push_one(12'h088, 160'h88);
    n_checks++; if (bus.occ !== 2'd2) begin n_fail++; $display("FAIL clr_pre_occ got %0d want 2", bus.occ); end
    Clr = 1'b1; bus.in_valid = 1'b1; bus.in_ctrl = 12'h099; bus.in_data = 160'h99; bus.out_ready = 1'b1;
    #1;
    n_checks++; if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL clr_during got rdy=%b vld=%b want 0/0", bus.in_ready, bus.out_valid); end
    step();
    Clr = 1'b0; bus.in_valid = 1'b0;
    #1;
    n_checks++; if (bus.occ !== 2'd0 || bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL clr_state got occ=%0d vld=%b want 0/0", bus.occ, bus.out_valid); end
    n_checks++; if (bus.out_ctrl !== 12'h0 || bus.out_data !== 160'h0) begin n_fail++; $display("FAIL clr_outputs got ctrl=%h data=%h want 0/0", bus.out_ctrl, bus.out_data); end
    step();
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL clr_no_stale got vld=%b data=%h want 0", bus.out_valid, bus.out_data); end
    bus.in_valid = 1'b1; bus.in_ctrl = 12'h0AB; bus.in_data = 160'hAB;
    #1;
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL clr_first_push_ready got %b want 1", bus.in_ready); end
    step();
    bus.in_valid = 1'b0;
    #1;
    n_checks++; if (bus.out_data !== 160'hAB || bus.occ !== 2'd1) begin n_fail++; $display("FAIL clr_first_push got data=%h occ=%0d want ab/1", bus.out_data, bus.occ); end
    step();
  endtask

  task automatic test_clr_first_edge();
    // Push presented on the very first edge after Clr drops
    Clr = 1'b1; step();
    Clr = 1'b0; bus.in_valid = 1'b1; bus.in_ctrl = 12'h0C3; bus.in_data = 160'hC3; bus.out_ready = 1'b0;
    step();
    bus.in_valid = 1'b0;
    #1;
    n_checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 160'hC3) begin n_fail++; $display("FAIL first_edge_push got vld=%b data=%h want 1/c3", bus.out_valid, bus.out_data); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_drain();
    test_flush();
    test_hold();
    test_back_to_back();
    test_clr_full();
    test_clr_first_edge();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
